// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812/SK6812 strip driver.
// Timing constants assume a 50 MHz clock.
package ws2812_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, LATCH} state_t;

    localparam int BPP_GRB  = 24;
    localparam int BPP_GRBW = 32;

    localparam int T0H_50M   = 20;
    localparam int T1H_50M   = 40;
    localparam int TBIT_50M  = 63;
    localparam int RESET_50M = 2500;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Generates one NRZ bit: high for T0H/T1H cycles, low for the rest of TBIT.
// last_cyc marks the final cycle of the bit so the next one can start seamlessly.
module ws2812_bit_timer #(
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int TBIT_CYC = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic last_cyc
);

    localparam int CW = $clog2(TBIT_CYC + 1);
    localparam logic [CW-1:0] T0H     = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H     = CW'(T1H_CYC);
    localparam logic [CW-1:0] TBIT_M1 = CW'(TBIT_CYC - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] hi_len;
    logic          running;

    assign cnt_nxt  = cnt + CW'(1);
    assign last_cyc = running && (cnt == TBIT_M1);

    // cnt counts cycles already spent in the bit; dout for the next cycle is
    // decided here so the pin is driven straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            cnt     <= '0;
            hi_len  <= '0;
            dout    <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            hi_len  <= bit_val ? T1H : T0H;
            dout    <= 1'b1;
        end else if (running) begin
            if (last_cyc) begin
                running <= 1'b0;
                dout    <= 1'b0;
            end else begin
                cnt  <= cnt_nxt;
                dout <= (cnt_nxt < hi_len);
            end
        end
    end

endmodule

// File: rtl/ws2812_strip_driver.sv
// Streams a frame of BPP-bit pixels MSB-first onto a WS2812 NRZ line,
// then holds the line low for the latch gap.
module ws2812_strip_driver
    import ws2812_pkg::*;
#(
    parameter int BPP       = BPP_GRB,
    parameter int NUM_LEDS  = 60,
    parameter int T0H_CYC   = T0H_50M,
    parameter int T1H_CYC   = T1H_50M,
    parameter int TBIT_CYC  = TBIT_50M,
    parameter int RESET_CYC = RESET_50M
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [BPP-1:0] pix_data,
    input  logic           pix_valid,
    input  logic           pix_last,
    output logic           pix_ready,
    output logic           dout,
    output logic           busy,
    output logic           underrun
);

    localparam int PW = $clog2(NUM_LEDS + 1);
    localparam int BW = $clog2(BPP);
    localparam int GW = $clog2(max2(TBIT_CYC, RESET_CYC) + 1);
    localparam logic [PW-1:0] LEDS_MAX = PW'(NUM_LEDS);
    localparam logic [BW-1:0] BIT_LAST = BW'(BPP - 1);
    localparam logic [GW-1:0] GAP_M1   = GW'(RESET_CYC - 1);

    state_t        state, state_nxt;
    logic [BPP-2:0] shreg;
    logic          last_q;
    logic [BW-1:0] bit_cnt;
    logic [PW-1:0] pix_cnt;
    logic [GW-1:0] gap_cnt;
    logic          rdy_en;
    logic          xfer;
    logic          bit_done;
    logic          last_bit;
    logic          frame_end;
    logic          gap_end;
    logic          next_bit;
    logic          und_set;
    logic          tmr_start;
    logic          tmr_bit;

    assign last_bit  = (bit_cnt == BIT_LAST);
    assign frame_end = last_q || (pix_cnt == LEDS_MAX);
    assign gap_end   = (gap_cnt == GAP_M1);
    assign xfer      = pix_valid && pix_ready;

    // The MSB goes straight to the timer; shreg holds only the bits still to send.
    assign tmr_start = xfer || next_bit;
    assign tmr_bit   = xfer ? pix_data[BPP-1] : shreg[BPP-2];

    ws2812_bit_timer #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .TBIT_CYC(TBIT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (tmr_start),
        .bit_val (tmr_bit),
        .dout    (dout),
        .last_cyc(bit_done)
    );

    // Mid-frame, a new pixel is only taken in the very last cycle of the
    // current one so consecutive pixels butt up with no gap.
    always_comb begin
        pix_ready = 1'b0;
        case (state)
            IDLE:    pix_ready = rdy_en;
            SEND:    pix_ready = bit_done && last_bit && !frame_end;
            WAIT:    pix_ready = 1'b1;
            default: pix_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        next_bit  = 1'b0;
        und_set   = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) state_nxt = SEND;
            end
            SEND: begin
                if (bit_done) begin
                    if (!last_bit)
                        next_bit = 1'b1;
                    else if (!xfer)
                        state_nxt = frame_end ? LATCH : WAIT;
                end
            end
            WAIT: begin
                if (xfer) begin
                    state_nxt = SEND;
                end else if (gap_end) begin
                    und_set   = 1'b1;
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                if (gap_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            last_q   <= 1'b0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            gap_cnt  <= '0;
            rdy_en   <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            rdy_en   <= 1'b1;
            underrun <= und_set;

            if (xfer) begin
                shreg   <= pix_data[BPP-2:0];
                last_q  <= pix_last;
                pix_cnt <= pix_cnt + PW'(1);
                bit_cnt <= '0;
                busy    <= 1'b1;
            end else if (next_bit) begin
                shreg   <= {shreg[BPP-3:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
            end

            // The gap counter restarts on every state change and only runs
            // in WAIT and LATCH.
            if (state_nxt != state)
                gap_cnt <= '0;
            else if (state == WAIT || state == LATCH)
                gap_cnt <= gap_cnt + GW'(1);

            if (state == LATCH && gap_end) begin
                busy    <= 1'b0;
                pix_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Scoreboard bench: stimulus queues expected bits (start cycle, high width),
// a forked monitor decodes dout and pops/compares on every falling edge.
module tb_ws2812_strip_driver;
    import ws2812_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pdata = '0;
    logic        plast = 1'b0;
    logic        v24 = 1'b0, v32 = 1'b0;
    logic        rdy24, rdy32, dout24, dout32, busy24, busy32, und24, und32;

    int cyc = 0;
    int checks = 0;
    int fails = 0;
    int und_cnt = 0;
    int und_cyc = -1;

    typedef struct {int start; int hi;} bit_t;
    bit_t expq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812_strip_driver #(.BPP(24), .NUM_LEDS(4), .T0H_CYC(3), .T1H_CYC(6),
                          .TBIT_CYC(10), .RESET_CYC(40)) dut24 (
        .clk(clk), .rst(rst), .pix_data(pdata[23:0]), .pix_valid(v24),
        .pix_last(plast), .pix_ready(rdy24), .dout(dout24), .busy(busy24),
        .underrun(und24));

    ws2812_strip_driver #(.BPP(32), .NUM_LEDS(4), .T0H_CYC(3), .T1H_CYC(6),
                          .TBIT_CYC(10), .RESET_CYC(40)) dut32 (
        .clk(clk), .rst(rst), .pix_data(pdata), .pix_valid(v32),
        .pix_last(plast), .pix_ready(rdy32), .dout(dout32), .busy(busy32),
        .underrun(und32));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon();
        logic dp, d;
        int   rc;
        bit_t e;
        dp = 1'b0;
        rc = 0;
        forever begin
            @(negedge clk);
            d = dout24 | dout32;
            if (d && !dp) rc = cyc;
            if (!d && dp) begin
                if (expq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_bit: start %0d high %0d", rc, cyc - rc);
                end else begin
                    e = expq.pop_front();
                    chk("bit_start", rc, e.start);
                    chk("bit_high", cyc - rc, e.hi);
                end
            end
            if (und24 || und32) begin
                und_cnt++;
                und_cyc = cyc;
            end
            dp = d;
        end
    endtask

    task automatic exp_pix(input int bpp, input logic [31:0] d, input int t0, input int n);
        bit_t e;
        for (int k = 0; k < n; k++) begin
            e.start = t0 + 10 * k;
            e.hi    = d[bpp-1-k] ? 6 : 3;
            expq.push_back(e);
        end
    endtask

    task automatic to_neg(input int c);
        int g;
        g = 0;
        @(negedge clk);
        while (cyc < c && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != c) chk("to_neg", cyc, c);
    endtask

    // Returns the edge number at which the pixel was accepted.
    task automatic drive_pixel(input bit sel, input logic [31:0] d, input logic last,
                               output int t);
        logic r;
        @(negedge clk);
        pdata = d;
        plast = last;
        if (sel) v32 = 1'b1; else v24 = 1'b1;
        t = -1;
        for (int i = 0; i < 3000 && t < 0; i++) begin
            r = sel ? rdy32 : rdy24;
            if (r) begin
                @(posedge clk);
                #1 t = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (t < 0) chk("xfer_timeout", 0, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        v24 = 1'b0;
        v32 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, t3, t4, t5, u0;
        fork
            mon();
        join_none

        // 1: reset with valid held high
        v24 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout", int'(dout24 | dout32), 0);
        chk("rst_ready", int'(rdy24 | rdy32), 0);
        chk("rst_busy", int'(busy24 | busy32), 0);
        chk("rst_underrun", int'(und24 | und32), 0);
        rst = 1'b1;
        #1 chk("ready_at_release", int'(rdy24), 0);
        @(posedge clk);
        #1 chk("ready_after_edge", int'(rdy24 & rdy32), 1);
        v24 = 1'b0;

        // 2: single last pixel AAAAAA
        drive_pixel(0, 32'h00AAAAAA, 1'b1, t);
        exp_pix(24, 32'h00AAAAAA, t, 24);
        idle();
        to_neg(t + 250);
        chk("latch_ready", int'(rdy24), 0);
        chk("latch_dout", int'(dout24), 0);
        to_neg(t + 279);
        chk("busy_279", int'(busy24), 1);
        to_neg(t + 280);
        chk("busy_280", int'(busy24), 0);
        chk("idle_ready", int'(rdy24), 1);

        // 3: 000000 then FFFFFF back to back
        drive_pixel(0, 32'h0, 1'b0, t);
        exp_pix(24, 32'h0, t, 24);
        exp_pix(24, 32'h00FFFFFF, t + 240, 24);
        drive_pixel(0, 32'h00FFFFFF, 1'b1, t2);
        chk("b2b_xfer", t2, t + 240);
        idle();
        to_neg(t + 519);
        chk("b2b_busy_519", int'(busy24), 1);
        to_neg(t + 520);
        chk("b2b_busy_520", int'(busy24), 0);

        // 4: NUM_LEDS cap forces a latch; 5th pixel waits for IDLE
        drive_pixel(0, 32'h00800000, 1'b0, t);
        exp_pix(24, 32'h00800000, t, 24);
        exp_pix(24, 32'h00000001, t + 240, 24);
        exp_pix(24, 32'h00F0F0F0, t + 480, 24);
        exp_pix(24, 32'h000F0F0F, t + 720, 24);
        exp_pix(24, 32'h00C00003, t + 1001, 24);
        drive_pixel(0, 32'h00000001, 1'b0, t2);
        drive_pixel(0, 32'h00F0F0F0, 1'b0, t3);
        drive_pixel(0, 32'h000F0F0F, 1'b0, t4);
        drive_pixel(0, 32'h00C00003, 1'b1, t5);
        chk("cap_xfer2", t2, t + 240);
        chk("cap_xfer3", t3, t + 480);
        chk("cap_xfer4", t4, t + 720);
        chk("cap_xfer5", t5, t + 1001);
        idle();
        to_neg(t + 1281);
        chk("cap_busy_end", int'(busy24), 0);
        chk("no_underrun_yet", und_cnt, 0);

        // 5a: stall of RESET_CYC cycles -> underrun then latch
        drive_pixel(0, 32'h005A5A5A, 1'b0, t);
        exp_pix(24, 32'h005A5A5A, t, 24);
        idle();
        to_neg(t + 279);
        chk("und_not_yet", und_cnt, 0);
        chk("wait_ready", int'(rdy24), 1);
        to_neg(t + 280);
        chk("und_count", und_cnt, 1);
        chk("und_cycle", und_cyc, t + 280);
        chk("und_ready", int'(rdy24), 0);
        to_neg(t + 319);
        chk("und_busy_319", int'(busy24), 1);
        to_neg(t + 320);
        chk("und_busy_320", int'(busy24), 0);
        chk("und_once", und_cnt, 1);

        // 5b: valid returns in the 40th wait cycle -> resumes, no underrun
        u0 = und_cnt;
        drive_pixel(0, 32'h00123456, 1'b0, t);
        exp_pix(24, 32'h00123456, t, 24);
        exp_pix(24, 32'h0000FF00, t + 280, 24);
        idle();
        to_neg(t + 278);
        drive_pixel(0, 32'h0000FF00, 1'b1, t2);
        chk("resume_xfer", t2, t + 280);
        idle();
        to_neg(t + 560);
        chk("resume_no_und", und_cnt - u0, 0);
        chk("resume_busy", int'(busy24), 0);

        // 6a: 32-bit GRBW pixel
        drive_pixel(1, 32'h80000001, 1'b1, t);
        exp_pix(32, 32'h80000001, t, 32);
        idle();
        to_neg(t + 359);
        chk("w_busy_359", int'(busy32), 1);
        to_neg(t + 360);
        chk("w_busy_360", int'(busy32), 0);

        // 6b: asynchronous reset during bit 10
        drive_pixel(1, 32'h80000001, 1'b1, t);
        exp_pix(32, 32'h80000001, t, 10);
        expq.push_back('{start: t + 100, hi: 2});
        idle();
        to_neg(t + 101);
        chk("pre_rst_dout", int'(dout32), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_dout", int'(dout32), 0);
        chk("async_state", int'(dut32.state), int'(IDLE));
        chk("async_busy", int'(busy32), 0);
        chk("async_ready", int'(rdy32), 0);
        to_neg(t + 104);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("rerelease_ready", int'(rdy32), 1);
        to_neg(t + 400);
        chk("exp_left", expq.size(), 0);
        chk("final_busy", int'(busy24 | busy32), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
